// File: rtl/control_sequencer_if.sv
// Control bundle between the SAP sequencer and its datapath: opcode/flags/run in,
// register, memory and ALU strobes out.
interface control_sequencer_if #(
  parameter int OPW     = 4,
  parameter int ALU_OPW = 3
);
  logic [OPW-1:0]     opcode;
  logic               zero_flag;
  logic               carry_flag;
  logic               run;
  logic               pc_inc;
  logic               pc_jmp;
  logic               mar_load;
  logic               mem_read;
  logic               mem_write;
  logic               ir_load;
  logic               acc_load;
  logic [1:0]         acc_src;
  logic               b_load;
  logic [ALU_OPW-1:0] alu_op;
  logic               flags_load;
  logic               out_load;
  logic               halted;
  logic               illegal_op;
  logic [2:0]         state;

  modport slave (
    input  opcode, zero_flag, carry_flag, run,
    output pc_inc, pc_jmp, mar_load, mem_read, mem_write, ir_load, acc_load,
           acc_src, b_load, alu_op, flags_load, out_load, halted, illegal_op, state
  );

  modport master (
    output opcode, zero_flag, carry_flag, run,
    input  pc_inc, pc_jmp, mar_load, mem_read, mem_write, ir_load, acc_load,
           acc_src, b_load, alu_op, flags_load, out_load, halted, illegal_op, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-T-state control sequencer for the SAP-class datapath; strobes are decoded
// combinationally from the registered state, the opcode and the flags.
//
// state  | meaning
// T0   0 | MAR <= PC when run, else stall
// T1   1 | fetch: IR <= RAM, PC++
// DEC  2 | decode; halt / nop / illegal resolve here
// EX1  3 | operand address, jumps, LDI, OUT
// EX2  4 | memory access for LDA/STA/ALU
// EX3  5 | ALU result into ACC and flags
// HALT 7 | parked until reset
module control_sequencer #(
  parameter int OPW     = 4,
  parameter int ALU_OPW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.slave   seq_if
);

  typedef enum logic [2:0] {
    S_T0     = 3'd0,
    S_T1     = 3'd1,
    S_DEC    = 3'd2,
    S_EX1    = 3'd3,
    S_EX2    = 3'd4,
    S_EX3    = 3'd5,
    S_UNUSED = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_XOR = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7,
                         OP_JC  = 4'h8, OP_JNZ = 4'h9, OP_STA = 4'hA, OP_LDI = 4'hB,
                         OP_NOP = 4'hC, OP_ILL = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  state_t state_q, state_d;

  logic [3:0]         op4;
  logic               op_illegal;
  logic               pc_inc, pc_jmp, mar_load, mem_read, mem_write, ir_load;
  logic               acc_load, b_load, flags_load, out_load, halted, illegal_op;
  logic [1:0]         acc_src;
  logic [ALU_OPW-1:0] alu_op;

  assign op4        = seq_if.opcode[3:0];
  assign op_illegal = ((seq_if.opcode >> 4) != '0) || (op4 == OP_ILL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_T0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_inc     = 1'b0;
    pc_jmp     = 1'b0;
    mar_load   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_load    = 1'b0;
    acc_load   = 1'b0;
    acc_src    = 2'b00;
    b_load     = 1'b0;
    alu_op     = '0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    // Reset masks every strobe so a store caught mid-EX2 is abandoned at once.
    if (!reset) begin
      case (state_q)
        S_T0: begin
          if (seq_if.run) begin
            mar_load = 1'b1;
            state_d  = S_T1;
          end
        end
        S_T1: begin
          mem_read = 1'b1;
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_DEC;
        end
        S_DEC: begin
          if (op_illegal) begin
            illegal_op = 1'b1;
            state_d    = S_T0;
          end else if (op4 == OP_HLT) state_d = S_HALT;
          else if (op4 == OP_NOP)     state_d = S_T0;
          else                        state_d = S_EX1;
        end
        S_EX1: begin
          state_d = S_T0;
          case (op4)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
              mar_load = 1'b1;
              state_d  = S_EX2;
            end
            // PC already advanced in T1, so an untaken jump needs no strobe.
            OP_JMP: pc_jmp = 1'b1;
            OP_JZ:  pc_jmp = seq_if.zero_flag;
            OP_JC:  pc_jmp = seq_if.carry_flag;
            OP_JNZ: pc_jmp = ~seq_if.zero_flag;
            OP_LDI: begin
              acc_load = 1'b1;
              acc_src  = 2'b10;
            end
            OP_OUT: out_load = 1'b1;
            default: ;
          endcase
        end
        S_EX2: begin
          state_d = S_T0;
          case (op4)
            OP_LDA: begin
              mem_read = 1'b1;
              acc_load = 1'b1;
            end
            OP_STA: mem_write = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              mem_read = 1'b1;
              b_load   = 1'b1;
              state_d  = S_EX3;
            end
            default: ;
          endcase
        end
        S_EX3: begin
          case (op4)
            OP_SUB:  alu_op = ALU_OPW'(1);
            OP_AND:  alu_op = ALU_OPW'(2);
            OP_OR:   alu_op = ALU_OPW'(3);
            OP_XOR:  alu_op = ALU_OPW'(4);
            default: alu_op = '0;
          endcase
          acc_load   = 1'b1;
          acc_src    = 2'b01;
          flags_load = 1'b1;
          state_d    = S_T0;
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_T0;
      endcase
    end
  end

  assign seq_if.pc_inc     = pc_inc;
  assign seq_if.pc_jmp     = pc_jmp;
  assign seq_if.mar_load   = mar_load;
  assign seq_if.mem_read   = mem_read;
  assign seq_if.mem_write  = mem_write;
  assign seq_if.ir_load    = ir_load;
  assign seq_if.acc_load   = acc_load;
  assign seq_if.acc_src    = acc_src;
  assign seq_if.b_load     = b_load;
  assign seq_if.alu_op     = alu_op;
  assign seq_if.flags_load = flags_load;
  assign seq_if.out_load   = out_load;
  assign seq_if.halted     = halted;
  assign seq_if.illegal_op = illegal_op;
  assign seq_if.state      = state_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised multi-T-state control sequencer for the SAP-class CPU datapath. It drives PC, MAR, IR, memory, accumulator, B register, ALU, flags and output register strobes. It extends the three-state fetch/decode/execute control with:
- explicit MAR/IR fetch
- memory store, immediate load and NOP
- carry and not-zero jumps
- a latched halt
- single-step stall
- illegal-opcode detection

Parameters:
OPW, 4, opcode width (>=4); bits above [3] must be zero for a legal opcode
ALU_OPW, 3, alu_op width (>=3); codes zero-extended

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces state T0 and all strobes 0 while high
opcode  in  OPW  IR opcode field; stable from DECODE onward
zero_flag  in  1  registered Z flag
carry_flag  in  1  registered C flag
run  in  1  1 = sequence; 0 = stall in T0 (single-step support)
pc_inc  out  1  PC <= PC+1
pc_jmp  out  1  PC <= IR operand
mar_load  out  1  MAR <= PC (T0) or IR operand (EX1)
mem_read  out  1  RAM drives bus
mem_write  out  1  RAM[MAR] <= ACC
ir_load  out  1  IR <= bus
acc_load  out  1  ACC <= selected source
acc_src  out  2  00 memory bus, 01 ALU, 10 IR immediate
b_load  out  1  B <= bus
alu_op  out  ALU_OPW  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
flags_load  out  1  Z/C <= ALU result flags
out_load  out  1  OUT <= ACC
halted  out  1  high while in HALT
illegal_op  out  1  one-cycle pulse in DECODE on illegal opcode
state  out  3  current state, for debug

Behaviour:
- All outputs are combinational from the registered state, opcode and flags.
- Outputs not listed for a state are 0. alu_op is 0 and acc_src is 00 by default.
- While reset is high, every output except state is 0, and state = T0.

State encoding and transitions:
- T0=0: if run=1, assert mar_load and go to T1. If run=0, hold T0 with no strobes.
- T1=1: mem_read, ir_load, pc_inc; go to DEC.
- DEC=2: no strobes.
  - HLT (F) -> HALT.
  - NOP (C) -> T0.
  - Illegal (D, or any nonzero opcode bit above [3]) -> pulse illegal_op, go to T0 (executes as NOP).
  - Everything else -> EX1.
- EX1=3:
  - LDA(0), ADD(1), SUB(2), AND(3), OR(4), XOR(5), STA(A): mar_load; go to EX2.
  - JMP(6): pc_jmp.
  - JZ(7): pc_jmp = zero_flag.
  - JC(8): pc_jmp = carry_flag.
  - JNZ(9): pc_jmp = ~zero_flag.
  - LDI(B): acc_load, acc_src=10.
  - OUT(E): out_load.
  - All EX1 cases other than the EX2 group above go to T0.
- EX2=4:
  - LDA: mem_read, acc_load, acc_src=00 -> T0.
  - STA: mem_write -> T0.
  - ALU ops: mem_read, b_load -> EX3.
- EX3=5: alu_op per opcode, acc_load, acc_src=01, flags_load -> T0.
- HALT=7: halted=1, no strobes. Exit only via reset.
- Unused code 6 -> T0 on the next clock.

Rules:
- Flags are sampled combinationally in EX1 only.
- pc_inc and pc_jmp are never both 1.
- A false conditional jump asserts nothing, because PC was already incremented in T1.
- Cycles per instruction (T0 to next T0, run=1):
  - NOP/illegal: 3
  - JMP/Jcc/LDI/OUT: 4
  - LDA/STA: 5
  - ALU: 6
  - HLT: 3 to HALT, then remains there
- run is examined only in T0. Deasserting run mid-instruction completes the instruction, then stalls in T0.
- Reset asserted in any state, including HALT and mid-EX2 STA, immediately deasserts mem_write and all strobes. Sequencing restarts in T0 on the first rising clk after release.

Test Plan:
- Reset, release with run=1 and opcode=0 (LDA): state sequence 0,1,2,3,4,0. mar_load at T0 and EX1; mem_read+ir_load+pc_inc at T1; mem_read+acc_load, acc_src=00 at EX2.
- opcode=2 (SUB): EX2 asserts b_load; EX3 asserts alu_op=1, acc_src=01, acc_load and flags_load. Total 6 cycles. Repeat for codes 1, 3, 4, 5 and check alu_op = 0, 2, 3, 4.
- opcode=7/8/9 with zero_flag/carry_flag each 0 and 1 in EX1: pc_jmp equals the expected condition and pc_inc=0 in EX1. JMP(6) always gives pc_jmp=1. Four cycles each.
- opcode=A (STA) -> mem_write=1 only in EX2. Assert reset mid-EX2 -> mem_write drops at once and state=0.
- opcode=F -> halted=1, state=7 held for 20 cycles with all strobes 0, regardless of run. Reset returns to T0 with halted=0.
- run=0 after reset: state stays 0 and mar_load=0 for 10 cycles. Then run=1 -> T1 next clock.
- opcode=D: illegal_op pulses for one cycle in DEC, next state T0, 3 cycles total. With OPW=6, opcode=6'h10 behaves the same way.
